// File: rtl/gmii_frame_rx.sv
// GMII receive framer: checks preamble/SFD, strips them and delivers payload bytes
// with sop/eop, length and error, plus an SFD pulse and good/bad frame counters.
module gmii_frame_rx #(
  parameter int MIN_PREAMBLE = 1,
  parameter int MIN_LEN      = 64,
  parameter int MAX_LEN      = 1522
) (
  input  logic        gmii_clk,
  input  logic        rst,
  input  logic        gmii_ctrl,
  input  logic [7:0]  gmii_data,
  output logic        sfd_det,
  output logic        frm_valid,
  output logic [7:0]  frm_data,
  output logic        frm_sop,
  output logic        frm_eop,
  output logic        frm_err,
  output logic [15:0] frm_len,
  output logic [15:0] frm_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [3:0]  MIN_PRE = 4'(MIN_PREAMBLE);
  localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L   = 16'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t      state, state_nxt;
  logic        ctrl_q;
  logic [7:0]  data_q;
  logic [3:0]  pre_cnt;
  logic [7:0]  hold;
  logic        hold_vld;
  logic        first;
  logic [15:0] len;
  logic        len_bad;
  logic        pre_start, pre_inc, go_sfd, ld_hold;
  logic        emit, eop, inc_err, inc_frm;

  assign len_bad = (len < MIN_L) || (len > MAX_L);

  always_ff @(posedge gmii_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Output is taken straight from the hold register so a byte surfaces two
  // cycles after it was on the wire; eop is known once ctrl_q drops.
  always_comb begin
    state_nxt = state;
    pre_start = 1'b0;
    pre_inc   = 1'b0;
    go_sfd    = 1'b0;
    ld_hold   = 1'b0;
    emit      = 1'b0;
    eop       = 1'b0;
    inc_err   = 1'b0;
    inc_frm   = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_q) begin
          if (data_q == 8'h55) begin
            state_nxt = PRE;
            pre_start = 1'b1;
          end else begin
            state_nxt = DROP;
            inc_err   = 1'b1;
          end
        end
      end
      PRE: begin
        if (!ctrl_q) begin
          state_nxt = IDLE;
        end else if (data_q == 8'h55) begin
          pre_inc = 1'b1;
        end else if (data_q == 8'hD5 && pre_cnt >= MIN_PRE) begin
          state_nxt = DATA;
          go_sfd    = 1'b1;
        end else begin
          state_nxt = DROP;
          inc_err   = 1'b1;
        end
      end
      DATA: begin
        if (ctrl_q) begin
          ld_hold = 1'b1;
          emit    = hold_vld;
        end else begin
          state_nxt = IDLE;
          if (hold_vld) begin
            emit    = 1'b1;
            eop     = 1'b1;
            inc_err = len_bad;
            inc_frm = !len_bad;
          end else begin
            inc_err = 1'b1;
          end
        end
      end
      DROP: begin
        if (!ctrl_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    frm_valid = emit;
    frm_data  = emit ? hold : 8'h00;
    frm_sop   = emit && first;
    frm_eop   = eop;
    frm_len   = eop ? len : 16'h0000;
    frm_err   = eop && len_bad;
  end

  // Control and counters
  always_ff @(posedge gmii_clk) begin
    if (rst) begin
      ctrl_q   <= 1'b0;
      pre_cnt  <= 4'h0;
      hold_vld <= 1'b0;
      first    <= 1'b0;
      len      <= 16'h0000;
      sfd_det  <= 1'b0;
      frm_cnt  <= 16'h0000;
      err_cnt  <= 16'h0000;
    end else begin
      ctrl_q  <= gmii_ctrl;
      sfd_det <= go_sfd;
      if (pre_start)                    pre_cnt <= 4'h1;
      else if (pre_inc && pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'h1;
      if (go_sfd) begin
        hold_vld <= 1'b0;
        first    <= 1'b1;
        len      <= 16'h0000;
      end else if (ld_hold) begin
        hold_vld <= 1'b1;
        if (len != 16'hFFFF) len <= len + 16'h0001;
      end else if (state == DATA && !ctrl_q) begin
        hold_vld <= 1'b0;
      end
      if (emit)    first   <= 1'b0;
      if (inc_frm) frm_cnt <= frm_cnt + 16'h0001;
      if (inc_err) err_cnt <= err_cnt + 16'h0001;
    end
  end

  // Data path (no reset; qualified by control above)
  always_ff @(posedge gmii_clk) begin
    data_q <= gmii_data;
    if (ld_hold) hold <= data_q;
  end

endmodule

// File: tb/tb_gmii_frame_rx.sv
// Directed bench for gmii_frame_rx: frame delivery, runt/giant, bad preamble,
// back-to-back frames, zero/one-byte payloads and reset behaviour.
`timescale 1ns/1ps
module tb_gmii_frame_rx;

  logic        gmii_clk = 1'b0;
  logic        rst;
  logic        gmii_ctrl;
  logic [7:0]  gmii_data;
  logic        sfd_det;
  logic        frm_valid;
  logic [7:0]  frm_data;
  logic        frm_sop;
  logic        frm_eop;
  logic        frm_err;
  logic [15:0] frm_len;
  logic [15:0] frm_cnt;
  logic [15:0] err_cnt;

  gmii_frame_rx dut (
    .gmii_clk  (gmii_clk),
    .rst       (rst),
    .gmii_ctrl (gmii_ctrl),
    .gmii_data (gmii_data),
    .sfd_det   (sfd_det),
    .frm_valid (frm_valid),
    .frm_data  (frm_data),
    .frm_sop   (frm_sop),
    .frm_eop   (frm_eop),
    .frm_err   (frm_err),
    .frm_len   (frm_len),
    .frm_cnt   (frm_cnt),
    .err_cnt   (err_cnt)
  );

  always #4 gmii_clk = ~gmii_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rx_q[$];
  int sop_q[$];
  int eop_q[$];
  int len_q[$];
  int err_q[$];
  int sfd_cnt  = 0;
  int side_bad = 0;

  // Passive monitor: records every delivered byte and framing marker.
  always @(negedge gmii_clk) begin
    if (sfd_det === 1'b1) sfd_cnt++;
    if (frm_valid === 1'b1) begin
      if (frm_sop) sop_q.push_back(rx_q.size());
      if (frm_eop) begin
        eop_q.push_back(rx_q.size());
        len_q.push_back(int'(frm_len));
        err_q.push_back(int'(frm_err));
      end
      rx_q.push_back(frm_data);
    end else if (frm_sop === 1'b1 || frm_eop === 1'b1) begin
      side_bad++;
    end
    if (frm_eop !== 1'b1 && (frm_len !== 16'h0000 || frm_err !== 1'b0)) side_bad++;
  end

  int b_rx, b_sop, b_eop, b_sfd;

  task automatic snap();
    b_rx  = rx_q.size();
    b_sop = sop_q.size();
    b_eop = eop_q.size();
    b_sfd = sfd_cnt;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic c, input logic [7:0] d);
    gmii_ctrl = c;
    gmii_data = d;
    @(posedge gmii_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 8'h00);
  endtask

  task automatic frame(input int npre, input int nlen, input logic [7:0] base);
    for (int i = 0; i < npre; i++) send(1'b1, 8'h55);
    send(1'b1, 8'hD5);
    for (int i = 0; i < nlen; i++) send(1'b1, base + 8'(i));
    send(1'b0, 8'h00);
  endtask

  function automatic int bad_bytes(input int start, input int n, input logic [7:0] base);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (start + i >= rx_q.size()) bad++;
      else if (rx_q[start + i] !== base + 8'(i)) bad++;
    end
    return bad;
  endfunction

  function automatic int sop_at(input int i);
    return (i < sop_q.size()) ? sop_q[i] : -1;
  endfunction

  function automatic int eop_at(input int i);
    return (i < eop_q.size()) ? eop_q[i] : -1;
  endfunction

  function automatic int len_at(input int i);
    return (i < len_q.size()) ? len_q[i] : -1;
  endfunction

  function automatic int err_at(input int i);
    return (i < err_q.size()) ? err_q[i] : -1;
  endfunction

  initial begin
    // Reset held with a live preamble byte on the wire
    rst       = 1'b1;
    gmii_ctrl = 1'b1;
    gmii_data = 8'h55;
    repeat (3) begin
      @(posedge gmii_clk);
      #1;
    end
    check("rst_flags", 32'({sfd_det, frm_valid, frm_sop, frm_eop, frm_err}), 32'd0);
    check("rst_data", 32'(frm_data), 32'd0);
    check("rst_len", 32'(frm_len), 32'd0);
    check("rst_frm_cnt", 32'(frm_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Nominal 64-byte frame; first 0x55 is the one present as reset drops
    snap();
    rst = 1'b0;
    frame(7, 64, 8'h00);
    idle(12);
    check("nom_sfd", 32'(sfd_cnt - b_sfd), 32'd1);
    check("nom_nbytes", 32'(rx_q.size() - b_rx), 32'd64);
    check("nom_bytes", 32'(bad_bytes(b_rx, 64, 8'h00)), 32'd0);
    check("nom_sop", 32'(sop_at(b_sop)), 32'(b_rx));
    check("nom_eop", 32'(eop_at(b_eop)), 32'(b_rx + 63));
    check("nom_len", 32'(len_at(b_eop)), 32'd64);
    check("nom_err", 32'(err_at(b_eop)), 32'd0);
    check("nom_frm_cnt", 32'(frm_cnt), 32'd1);
    check("nom_err_cnt", 32'(err_cnt), 32'd0);

    // Runt
    snap();
    frame(7, 10, 8'h80);
    idle(3);
    check("runt_nbytes", 32'(rx_q.size() - b_rx), 32'd10);
    check("runt_bytes", 32'(bad_bytes(b_rx, 10, 8'h80)), 32'd0);
    check("runt_len", 32'(len_at(b_eop)), 32'd10);
    check("runt_err", 32'(err_at(b_eop)), 32'd1);
    check("runt_err_cnt", 32'(err_cnt), 32'd1);
    check("runt_frm_cnt", 32'(frm_cnt), 32'd1);

    // Giant
    snap();
    frame(7, 1600, 8'h00);
    idle(3);
    check("giant_nbytes", 32'(rx_q.size() - b_rx), 32'd1600);
    check("giant_len", 32'(len_at(b_eop)), 32'd1600);
    check("giant_err", 32'(err_at(b_eop)), 32'd1);
    check("giant_err_cnt", 32'(err_cnt), 32'd2);

    // Corrupted preamble byte
    snap();
    for (int i = 0; i < 3; i++) send(1'b1, 8'h55);
    send(1'b1, 8'h12);
    for (int i = 0; i < 20; i++) send(1'b1, 8'(i));
    send(1'b0, 8'h00);
    idle(3);
    check("badpre_nbytes", 32'(rx_q.size() - b_rx), 32'd0);
    check("badpre_sfd", 32'(sfd_cnt - b_sfd), 32'd0);
    check("badpre_err_cnt", 32'(err_cnt), 32'd3);

    // SFD with no preamble at all
    snap();
    send(1'b1, 8'hD5);
    for (int i = 0; i < 5; i++) send(1'b1, 8'h10);
    send(1'b0, 8'h00);
    idle(3);
    check("nopre_nbytes", 32'(rx_q.size() - b_rx), 32'd0);
    check("nopre_sfd", 32'(sfd_cnt - b_sfd), 32'd0);
    check("nopre_err_cnt", 32'(err_cnt), 32'd4);

    // Back-to-back frames with a single idle cycle between them
    snap();
    frame(7, 64, 8'h00);
    frame(7, 64, 8'h40);
    idle(3);
    check("b2b_nbytes", 32'(rx_q.size() - b_rx), 32'd128);
    check("b2b_bytes", 32'(bad_bytes(b_rx, 128, 8'h00)), 32'd0);
    check("b2b_nsop", 32'(sop_q.size() - b_sop), 32'd2);
    check("b2b_sop2", 32'(sop_at(b_sop + 1)), 32'(b_rx + 64));
    check("b2b_eop1", 32'(eop_at(b_eop)), 32'(b_rx + 63));
    check("b2b_eop2", 32'(eop_at(b_eop + 1)), 32'(b_rx + 127));
    check("b2b_len2", 32'(len_at(b_eop + 1)), 32'd64);
    check("b2b_frm_cnt", 32'(frm_cnt), 32'd3);
    check("b2b_err_cnt", 32'(err_cnt), 32'd4);

    // Zero-length payload
    snap();
    frame(7, 0, 8'h00);
    idle(3);
    check("zero_sfd", 32'(sfd_cnt - b_sfd), 32'd1);
    check("zero_nbytes", 32'(rx_q.size() - b_rx), 32'd0);
    check("zero_neop", 32'(eop_q.size() - b_eop), 32'd0);
    check("zero_err_cnt", 32'(err_cnt), 32'd5);

    // Single-byte payload, checked cycle by cycle
    for (int i = 0; i < 7; i++) send(1'b1, 8'h55);
    send(1'b1, 8'hD5);
    send(1'b1, 8'hA5);
    check("one_sfd_pulse", 32'(sfd_det), 32'd1);
    check("one_early_valid", 32'(frm_valid), 32'd0);
    send(1'b0, 8'h00);
    check("one_flags", 32'({frm_valid, frm_sop, frm_eop}), 32'd7);
    check("one_data", 32'(frm_data), 32'hA5);
    check("one_len", 32'(frm_len), 32'd1);
    check("one_err", 32'(frm_err), 32'd1);
    idle(1);
    check("one_after_valid", 32'(frm_valid), 32'd0);
    idle(2);
    check("one_err_cnt", 32'(err_cnt), 32'd6);
    check("one_frm_cnt", 32'(frm_cnt), 32'd3);

    // Reset pulsed mid-payload
    snap();
    for (int i = 0; i < 7; i++) send(1'b1, 8'h55);
    send(1'b1, 8'hD5);
    for (int i = 0; i < 20; i++) send(1'b1, 8'(i));
    rst = 1'b1;
    send(1'b1, 8'h99);
    rst = 1'b0;
    idle(4);
    check("midrst_neop", 32'(eop_q.size() - b_eop), 32'd0);
    check("midrst_frm_cnt", 32'(frm_cnt), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);

    snap();
    frame(7, 64, 8'h20);
    idle(3);
    check("recov_bytes", 32'(bad_bytes(b_rx, 64, 8'h20)), 32'd0);
    check("recov_len", 32'(len_at(b_eop)), 32'd64);
    check("recov_frm_cnt", 32'(frm_cnt), 32'd1);

    check("side_signals", 32'(side_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
